// File: rtl/video_pattern_gen.sv
// Frame-aware test pattern generator: border/diagonal, colour bars, checkerboard
// and a bouncing box. Pattern and animation state change only on frame_start.
module video_pattern_gen #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int BOX_SIZE          = 32,
  parameter int CHECKER_LOG2      = 4,
  parameter int INVERT_PERIOD     = 60,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic [1:0]         mode_req,
  input  logic               mode_req_valid,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               rgb_valid,
  output logic [1:0]         mode
);

  typedef enum logic [1:0] {
    PAT_BORDER_DIAG = 2'd0,
    PAT_COLOR_BARS  = 2'd1,
    PAT_CHECKER     = 2'd2,
    PAT_BOX         = 2'd3
  } pattern_t;

  localparam int PW = X_WIDTH + Y_WIDTH + 1;
  localparam int BW = X_WIDTH + 4;
  localparam int FW = (INVERT_PERIOD > 1) ? $clog2(INVERT_PERIOD) : 1;
  localparam logic [X_WIDTH-1:0] X_LAST     = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST     = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);
  localparam logic [X_WIDTH-1:0] BX_MAX     = X_WIDTH'(HOR_ACTIVE_PIXELS - BOX_SIZE);
  localparam logic [Y_WIDTH-1:0] BY_MAX     = Y_WIDTH'(VER_ACTIVE_PIXELS - BOX_SIZE);
  localparam logic [FW-1:0]      FRAME_LAST = FW'(INVERT_PERIOD - 1);
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  logic [1:0]         pending;
  logic [X_WIDTH-1:0] bx;
  logic [Y_WIDTH-1:0] by;
  logic               dx_neg, dy_neg;
  logic [FW-1:0]      frame_cnt;
  logic               phase;

  logic [PW-1:0] diag_d;
  logic [2:0]    bar;
  logic          border_hit, checker_white, box_hit;
  logic [23:0]   rgb_p0;

  // Stage p0: combinational pattern evaluation from the current frame state
  always_comb begin
    diag_d = PW'(x) * PW'(VER_ACTIVE_PIXELS) / PW'(HOR_ACTIVE_PIXELS);
    bar    = 3'((BW'(x) << 3) / BW'(HOR_ACTIVE_PIXELS));
    border_hit = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST) ||
                 (PW'(y) == diag_d) || (PW'(y) == PW'(VER_ACTIVE_PIXELS - 1) - diag_d);
    // The square holding pixel (0,0) is white while phase is 0.
    checker_white = ~(x[CHECKER_LOG2] ^ y[CHECKER_LOG2] ^ phase);
    box_hit = (x >= bx) && (y >= by) &&
              ((X_WIDTH+1)'(x) < (X_WIDTH+1)'(bx) + (X_WIDTH+1)'(BOX_SIZE)) &&
              ((Y_WIDTH+1)'(y) < (Y_WIDTH+1)'(by) + (Y_WIDTH+1)'(BOX_SIZE));
    rgb_p0 = BLACK;
    if (pixel_valid) begin
      case (pattern_t'(mode))
        PAT_BORDER_DIAG: rgb_p0 = border_hit ? 24'hFF0000 : WHITE;
        PAT_COLOR_BARS:  rgb_p0 = bar_colour(bar);
        PAT_CHECKER:     rgb_p0 = checker_white ? WHITE : BLACK;
        default:         rgb_p0 = box_hit ? 24'h00FF00 : BLACK;
      endcase
    end
  end

  // Stage p1: registered pixel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      rgb_valid <= 1'b0;
    end else begin
      r         <= rgb_p0[23:16];
      g         <= rgb_p0[15:8];
      b         <= rgb_p0[7:0];
      rgb_valid <= pixel_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= '0;
      pending   <= '0;
      bx        <= '0;
      by        <= '0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (mode_req_valid) pending <= mode_req;
      if (frame_start) begin
        mode <= mode_req_valid ? mode_req : pending;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        // A step that would cross a limit reflects off it in the same update.
        if (!dx_neg) begin
          if (bx >= BX_MAX) begin
            bx     <= BX_MAX - 1'b1;
            dx_neg <= 1'b1;
          end else bx <= bx + 1'b1;
        end else begin
          if (bx == '0) begin
            bx     <= X_WIDTH'(1);
            dx_neg <= 1'b0;
          end else bx <= bx - 1'b1;
        end
        if (!dy_neg) begin
          if (by >= BY_MAX) begin
            by     <= BY_MAX - 1'b1;
            dy_neg <= 1'b1;
          end else by <= by + 1'b1;
        end else begin
          if (by == '0) begin
            by     <= Y_WIDTH'(1);
            dy_neg <= 1'b0;
          end else by <= by - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen; a frame-indexed reference model
// predicts every pixel, the mode register and the bouncing-box position.
module tb_video_pattern_gen;

  localparam int HOR = 640;
  localparam int VER = 480;
  localparam int BOX = 32;
  localparam int CL  = 4;
  localparam int INV = 2;
  localparam int XW  = $clog2(HOR);
  localparam int YW  = $clog2(VER);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic          pixel_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [1:0]    mode_req = '0;
  logic          mode_req_valid = 1'b0;
  logic [7:0]    r, g, b;
  logic          rgb_valid;
  logic [1:0]    mode;

  int n_pass = 0;
  int n_total = 0;
  int m_k = 0;
  int m_mode = 0;
  int m_pending = 0;

  video_pattern_gen #(
    .HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER), .BOX_SIZE(BOX),
    .CHECKER_LOG2(CL), .INVERT_PERIOD(INV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .r(r), .g(g), .b(b), .rgb_valid(rgb_valid), .mode(mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, got running want finished");
    $fatal(1);
  end

  // Box position after k frames is a triangle wave over 0..lim.
  function automatic int tri_pos(input int k, input int lim);
    int p;
    p = k % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic logic [23:0] exp_rgb(input int md, input int xx, input int yy, input int k);
    int d, bar, ph, bxp, byp;
    logic [23:0] res;
    res = 24'h000000;
    case (md)
      0: begin
        d = (xx * VER) / HOR;
        res = (xx == 0 || xx == HOR-1 || yy == 0 || yy == VER-1 || yy == d || yy == VER-1-d)
              ? 24'hFF0000 : 24'hFFFFFF;
      end
      1: begin
        bar = (xx * 8) / HOR;
        case (bar)
          0: res = 24'hFFFFFF;
          1: res = 24'hFFFF00;
          2: res = 24'h00FFFF;
          3: res = 24'h00FF00;
          4: res = 24'hFF00FF;
          5: res = 24'hFF0000;
          6: res = 24'h0000FF;
          default: res = 24'h000000;
        endcase
      end
      2: begin
        ph = (k / INV) % 2;
        res = ((((xx >> CL) + (yy >> CL) + ph) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      end
      default: begin
        bxp = tri_pos(k, HOR - BOX);
        byp = tri_pos(k, VER - BOX);
        res = (xx >= bxp && xx < bxp + BOX && yy >= byp && yy < byp + BOX) ? 24'h00FF00 : 24'h000000;
      end
    endcase
    return res;
  endfunction

  task automatic drive(input int xx, input int yy, input logic pv, input logic fs,
                       input logic mrv, input int mr);
    @(negedge clk);
    x = XW'(xx);
    y = YW'(yy);
    pixel_valid = pv;
    frame_start = fs;
    mode_req_valid = mrv;
    mode_req = 2'(mr);
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    mode_req_valid = 1'b0;
    if (fs) begin
      m_mode = mrv ? mr : m_pending;
      m_k++;
    end
    if (mrv) m_pending = mr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_k = 0;
    m_mode = 0;
    m_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] exp;
    #3;
    n_total++;
    if ({r, g, b, rgb_valid, mode} !== '0)
      $display("FAIL reset_initial got %h want 0", {r, g, b, rgb_valid, mode});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 3);
    exp = exp_rgb(m_mode, 1, 1, m_k);
    drive(1, 1, 1'b1, 1'b0, 1'b0, 0);
    n_total++;
    if ({r, g, b, rgb_valid} !== {24'h00FF00, 1'b1} || exp !== 24'h00FF00)
      $display("FAIL reset_pre_box got %h/%b want 00ff00/1", {r, g, b}, rgb_valid);
    else n_pass++;
    @(negedge clk);
    x = XW'(1); y = YW'(1); pixel_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({r, g, b, rgb_valid, mode} !== '0)
      $display("FAIL reset_async got %h want 0", {r, g, b, rgb_valid, mode});
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({r, g, b, rgb_valid, mode} !== '0)
      $display("FAIL reset_held got %h want 0", {r, g, b, rgb_valid, mode});
    else n_pass++;
    @(negedge clk);
    pixel_valid = 1'b0;
    rst_n = 1'b1;
    m_k = 0; m_mode = 0; m_pending = 0;
  endtask

  task automatic test_border();
    int xs[3] = '{0, 320, 100};
    int ys[3] = '{5, 240, 100};
    logic [23:0] want[3] = '{24'hFF0000, 24'hFF0000, 24'hFFFFFF};
    int xx, yy;
    logic [23:0] exp;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(xs[i], ys[i], 1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if ({r, g, b} !== want[i])
        $display("FAIL border_point x=%0d y=%0d got %h want %h", xs[i], ys[i], {r, g, b}, want[i]);
      else n_pass++;
    end
    for (int i = 0; i < 20; i++) begin
      xx = $urandom_range(HOR - 1);
      yy = $urandom_range(VER - 1);
      if (i % 4 == 0) yy = (xx * VER) / HOR;
      exp = exp_rgb(m_mode, xx, yy, m_k);
      drive(xx, yy, 1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if ({r, g, b} !== exp)
        $display("FAIL border_rand x=%0d y=%0d got %h want %h", xx, yy, {r, g, b}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_mode_handshake();
    int xx, yy;
    logic [23:0] exp;
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1);
    n_total++;
    if (mode !== 2'd0) $display("FAIL hs_req1_hold got %0d want 0", mode); else n_pass++;
    drive(5, 5, 1'b1, 1'b0, 1'b1, 2);
    n_total++;
    if (mode !== 2'd0) $display("FAIL hs_req2_hold got %0d want 0", mode); else n_pass++;
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0);
    n_total++;
    if (mode !== 2'd2) $display("FAIL hs_apply got %0d want 2", mode); else n_pass++;
    xx = $urandom_range(HOR - 1);
    yy = $urandom_range(VER - 1);
    exp = exp_rgb(m_mode, xx, yy, m_k);
    drive(xx, yy, 1'b1, 1'b0, 1'b0, 0);
    n_total++;
    if ({r, g, b} !== exp) $display("FAIL hs_pixel got %h want %h", {r, g, b}, exp); else n_pass++;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 3);
    n_total++;
    if (mode !== 2'd3) $display("FAIL hs_coincident got %0d want 3", mode); else n_pass++;
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0);
    n_total++;
    if (mode !== 2'd3) $display("FAIL hs_keep got %0d want 3", mode); else n_pass++;
  endtask

  task automatic test_color_bars();
    int xs[4] = '{0, 80, 559, 639};
    logic [23:0] want[4] = '{24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000};
    logic pvs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int xx, yy;
    logic [23:0] exp;
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      yy = $urandom_range(VER - 1);
      drive(xs[i], yy, 1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if ({r, g, b} !== want[i])
        $display("FAIL bars_point x=%0d got %h want %h", xs[i], {r, g, b}, want[i]);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      xx = $urandom_range(HOR - 1);
      yy = $urandom_range(VER - 1);
      exp = pvs[i] ? exp_rgb(m_mode, xx, yy, m_k) : 24'h000000;
      drive(xx, yy, pvs[i], 1'b0, 1'b0, 0);
      n_total++;
      if ({r, g, b, rgb_valid} !== {exp, pvs[i]})
        $display("FAIL bars_valid i=%0d got %h/%b want %h/%b", i, {r, g, b}, rgb_valid, exp, pvs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_checker();
    logic [23:0] want00[4] = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};
    int xx, yy;
    logic [23:0] exp;
    do_reset();
    drive(0, 0, 1'b0, 1'b1, 1'b1, 2);
    drive(16, 0, 1'b1, 1'b0, 1'b0, 0);
    n_total++;
    if ({r, g, b} !== 24'h000000) $display("FAIL checker_16_0 got %h want 000000", {r, g, b}); else n_pass++;
    for (int f = 0; f < 4; f++) begin
      if (f > 0) drive(0, 0, 1'b0, 1'b1, 1'b0, 0);
      drive(0, 0, 1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if ({r, g, b} !== want00[f])
        $display("FAIL checker_0_0 frame=%0d got %h want %h", m_k, {r, g, b}, want00[f]);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
        xx = $urandom_range(HOR - 1);
        yy = $urandom_range(VER - 1);
        exp = exp_rgb(m_mode, xx, yy, m_k);
        drive(xx, yy, 1'b1, 1'b0, 1'b0, 0);
        n_total++;
        if ({r, g, b} !== exp)
          $display("FAIL checker_rand x=%0d y=%0d got %h want %h", xx, yy, {r, g, b}, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_box_bounce();
    int px[8]  = '{448, 448, 449, 449, 608, 607, 639, 607};
    int py[8]  = '{479, 447, 479, 447, 288, 288, 288, 287};
    int fr[8]  = '{448, 448, 449, 449, 608, 608, 608, 609};
    logic [23:0] want[8] = '{24'h00FF00, 24'h000000, 24'h000000, 24'h00FF00,
                             24'h00FF00, 24'h000000, 24'h00FF00, 24'h00FF00};
    do_reset();
    drive(0, 0, 1'b0, 1'b1, 1'b1, 3);
    for (int i = 0; i < 8; i++) begin
      while (m_k < fr[i]) drive(0, 0, 1'b0, 1'b1, 1'b0, 0);
      drive(px[i], py[i], 1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if ({r, g, b} !== want[i])
        $display("FAIL box_point frame=%0d x=%0d y=%0d got %h want %h", m_k, px[i], py[i], {r, g, b}, want[i]);
      else n_pass++;
    end
    drive(639, 287, 1'b1, 1'b0, 1'b0, 0);
    n_total++;
    if ({r, g, b} !== exp_rgb(3, 639, 287, m_k))
      $display("FAIL box_edge got %h want %h", {r, g, b}, exp_rgb(3, 639, 287, m_k));
    else n_pass++;
  endtask

  task automatic test_random();
    int xx, yy, md;
    logic pv;
    logic [23:0] exp;
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(1) == 1) drive(0, 0, 1'b0, 1'b0, 1'b1, $urandom_range(3));
      md = $urandom_range(3);
      drive(0, 0, 1'b0, 1'b1, 1'($urandom_range(1)), md);
      n_total++;
      if (mode !== 2'(m_mode)) $display("FAIL rand_mode got %0d want %0d", mode, m_mode); else n_pass++;
      for (int i = 0; i < 20; i++) begin
        xx = $urandom_range(HOR - 1);
        yy = $urandom_range(VER - 1);
        pv = 1'($urandom_range(3) != 0);
        exp = pv ? exp_rgb(m_mode, xx, yy, m_k) : 24'h000000;
        drive(xx, yy, pv, 1'b0, 1'b0, 0);
        n_total++;
        if ({r, g, b, rgb_valid} !== {exp, pv})
          $display("FAIL rand_pixel mode=%0d x=%0d y=%0d got %h/%b want %h/%b",
                   m_mode, xx, yy, {r, g, b}, rgb_valid, exp, pv);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_border();
    test_mode_handshake();
    test_color_bars();
    test_checker();
    test_box_bounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
